// File: rtl/magic_nmi_pkg.sv
// Shared types and constants for the magic-button NMI controller.
package magic_nmi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NMI,
    WAIT_VEC,
    MAPPED,
    UNMAP
  } nmi_state_t;

  localparam logic [15:0] NMI_VECTOR = 16'h0066;
  localparam logic [7:0]  OPC_ED     = 8'hED;
  localparam logic [7:0]  OPC_RETI   = 8'h4D;

  // Second byte of an ED-prefixed RETN (any mirror), with RETI excluded.
  function automatic logic is_retn_opc(input logic [7:0] opc);
    return (opc[7:6] == 2'b01) && (opc[2:0] == 3'b101) && (opc != OPC_RETI);
  endfunction

endpackage

// File: rtl/cpu_bus.sv
// Read-only view of the CPU address/data/control bus used by bus monitors.
interface cpu_bus;
  logic [15:0] a;
  logic [7:0]  d;
  logic        m1;
  logic        mreq;
  logic        rd;

  modport mon (input a, d, m1, mreq, rd);
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter; emits the debounced level and a rise strobe.
module button_debounce #(
  parameter int DEBOUNCE_BITS = 12
) (
  input  logic clkcpu,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic rise
);

  logic                     sync_p0;
  logic                     sync_p1;
  logic [DEBOUNCE_BITS-1:0] cnt;

  // The level flips on the 2^DEBOUNCE_BITS-th consecutive edge that disagrees with it.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        cnt   <= '0;
        level <= sync_p1;
        rise  <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/magic_nmi.sv
// Magic-button NMI controller: debounced press -> fixed NMI pulse, then maps the
// service ROM from the 0x0066 vector fetch until the handler's RETN.
module magic_nmi
  import magic_nmi_pkg::*;
#(
  parameter int DEBOUNCE_BITS  = 12,
  parameter int NMI_LEN        = 24,
  parameter int VECTOR_TIMEOUT = 255
) (
  input  logic clkcpu,
  input  logic rst_n,
  cpu_bus.mon  bus,
  input  logic magic_button,
  input  logic n_int,
  output logic n_nmi,
  output logic magic_map,
  output logic magic_active
);

  localparam logic [7:0] NMI_LAST = 8'(NMI_LEN - 1);
  localparam logic [7:0] TO_LAST  = 8'(VECTOR_TIMEOUT - 1);

  logic        press;
  logic        unused_btn_level;
  logic        fetch;
  logic        fetch_d;
  logic        fetch_end;
  logic [7:0]  opc;
  logic [15:0] fa;
  logic        ed_pfx;
  logic        retn;
  nmi_state_t  state;
  nmi_state_t  state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        pend;
  logic        pend_nxt;
  logic        map_r;

  button_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .clkcpu (clkcpu),
    .rst_n  (rst_n),
    .button (magic_button),
    .level  (unused_btn_level),
    .rise   (press)
  );

  assign fetch     = bus.m1 && bus.mreq && bus.rd;
  assign fetch_end = fetch_d && !fetch;
  assign retn      = fetch_end && ed_pfx && is_retn_opc(opc);

  // Fetch capture: opc/fa hold the last completed opcode fetch.
  always_ff @(posedge clkcpu) begin
    if (fetch) begin
      opc <= bus.d;
      fa  <= bus.a;
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      fetch_d <= 1'b0;
      ed_pfx  <= 1'b0;
    end else begin
      fetch_d <= fetch;
      if (fetch_end) ed_pfx <= (opc == OPC_ED);
    end
  end

  // Next state; a press seen while n_int is low is held in pend until n_int rises.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    case (state)
      IDLE: begin
        if ((press || pend) && n_int) begin
          state_nxt = NMI;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end else if (press) begin
          pend_nxt = 1'b1;
        end
      end
      NMI: begin
        if (cnt == NMI_LAST) begin
          state_nxt = WAIT_VEC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      WAIT_VEC: begin
        if (fetch_end) begin
          if (fa == NMI_VECTOR) begin
            state_nxt = MAPPED;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      MAPPED: if (retn) state_nxt = UNMAP;
      UNMAP:  if (fetch_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pend         <= 1'b0;
      n_nmi        <= 1'b1;
      magic_active <= 1'b0;
      map_r        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pend         <= pend_nxt;
      n_nmi        <= (state_nxt != NMI);
      magic_active <= (state_nxt != IDLE);
      map_r        <= (state_nxt == MAPPED) || (state_nxt == UNMAP);
    end
  end

  // The vector byte itself must already come from the service ROM.
  assign magic_map = map_r || ((state == WAIT_VEC) && fetch && (bus.a == NMI_VECTOR));

endmodule

// File: tb/tb_magic_nmi.sv
// Directed bench for magic_nmi (DEBOUNCE_BITS=4, NMI_LEN=24, VECTOR_TIMEOUT=3).
module tb_magic_nmi;

  logic clkcpu = 1'b0;
  logic rst_n = 1'b0;
  logic magic_button = 1'b0;
  logic n_int = 1'b1;
  logic n_nmi;
  logic magic_map;
  logic magic_active;

  int checks = 0;
  int errors = 0;

  cpu_bus bus_if();

  magic_nmi #(
    .DEBOUNCE_BITS(4),
    .NMI_LEN(24),
    .VECTOR_TIMEOUT(3)
  ) dut (
    .clkcpu       (clkcpu),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .magic_button (magic_button),
    .n_int        (n_int),
    .n_nmi        (n_nmi),
    .magic_map    (magic_map),
    .magic_active (magic_active)
  );

  always #5 clkcpu = ~clkcpu;

  task automatic cyc(input int n);
    repeat (n) @(posedge clkcpu);
    #1;
  endtask

  // Returns the index of the first negedge with n_nmi low, 0 if none within bound.
  task automatic wait_fall(input int bound, output int at);
    at = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clkcpu);
      if (n_nmi === 1'b0) begin
        at = i;
        break;
      end
    end
  endtask

  // Called at a negedge where n_nmi is low; counts low negedges including that one.
  task automatic measure_low(output int len);
    len = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clkcpu);
      if (n_nmi !== 1'b0) break;
      len++;
    end
  endtask

  // Two-cycle opcode fetch followed by two idle cycles; map_during sampled mid-fetch.
  task automatic fetch(input logic [15:0] addr, input logic [7:0] data, output logic map_during);
    @(posedge clkcpu); #1;
    bus_if.a = addr; bus_if.d = data;
    bus_if.m1 = 1'b1; bus_if.mreq = 1'b1; bus_if.rd = 1'b1;
    @(negedge clkcpu);
    map_during = magic_map;
    @(posedge clkcpu); #1;
    @(posedge clkcpu); #1;
    bus_if.m1 = 1'b0; bus_if.mreq = 1'b0; bus_if.rd = 1'b0;
    @(posedge clkcpu); #1;
    @(posedge clkcpu); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL reset_n_nmi: got %b expected 1", n_nmi); end
    checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL reset_map: got %b expected 0", magic_map); end
    checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", magic_active); end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_bounce;
    int at, len;
    bit ok;
    ok = 1'b1; len = 0;
    for (int i = 0; i < 40; i++) begin
      magic_button = ((i / 3) % 2 == 0);
      @(negedge clkcpu);
      if (n_nmi !== 1'b1) ok = 1'b0;
      @(posedge clkcpu); #1;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bounce_no_nmi: got %b expected 1", ok); end
    magic_button = 1'b1;
    wait_fall(40, at);
    checks++; if (at == 0) begin errors++; $display("FAIL bounce_press_seen: got %0d expected nonzero", at); end
    if (at != 0) measure_low(len);
    checks++; if (len != 24) begin errors++; $display("FAIL bounce_pulse_len: got %0d expected 24", len); end
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkcpu);
      if (n_nmi !== 1'b1) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bounce_single_press: got %b expected 1", ok); end
    magic_button = 1'b0;
    cyc(1);
  endtask

  task automatic test_timeout;
    logic m;
    for (int i = 0; i < 3; i++) begin
      fetch(16'h8000, 8'h00, m);
      checks++; if (m !== 1'b0) begin errors++; $display("FAIL timeout_map_%0d: got %b expected 0", i, m); end
      checks++;
      if (magic_active !== (i < 2)) begin
        errors++; $display("FAIL timeout_active_%0d: got %b expected %b", i, magic_active, (i < 2));
      end
    end
    checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL timeout_map_idle: got %b expected 0", magic_map); end
  endtask

  task automatic test_int_delay;
    int at, len;
    bit ok;
    logic m;
    cyc(20);
    n_int = 1'b0;
    magic_button = 1'b1;
    ok = 1'b1; len = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clkcpu);
      if (n_nmi !== 1'b1) ok = 1'b0;
      @(posedge clkcpu); #1;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL int_hold_off: got %b expected 1", ok); end
    n_int = 1'b1;
    wait_fall(4, at);
    checks++; if (at != 2) begin errors++; $display("FAIL int_release_edge: got %0d expected 2", at); end
    if (at != 0) measure_low(len);
    checks++; if (len != 24) begin errors++; $display("FAIL int_pulse_len: got %0d expected 24", len); end
    magic_button = 1'b0;
    for (int i = 0; i < 3; i++) fetch(16'h8000, 8'h00, m);
    checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL int_back_idle: got %b expected 0", magic_active); end
  endtask

  task automatic test_map;
    int at, len;
    logic m;
    cyc(20);
    magic_button = 1'b1;
    wait_fall(40, at);
    checks++; if (at == 0) begin errors++; $display("FAIL map_press: got %0d expected nonzero", at); end
    if (at != 0) measure_low(len);
    magic_button = 1'b0;
    fetch(16'h0066, 8'hF5, m);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL map_vector_fetch: got %b expected 1", m); end
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL map_after_vector: got %b expected 1", magic_map); end
    fetch(16'h0067, 8'hED, m);
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL map_after_ed: got %b expected 1", magic_map); end
    fetch(16'h0068, 8'h45, m);
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL map_after_retn: got %b expected 1", magic_map); end
    fetch(16'h1234, 8'h00, m);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL map_return_fetch: got %b expected 1", m); end
    checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL map_dropped: got %b expected 0", magic_map); end
    checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL map_idle: got %b expected 0", magic_active); end
  endtask

  task automatic test_reti;
    int at, len;
    bit ok;
    logic m;
    cyc(20);
    magic_button = 1'b1;
    wait_fall(40, at);
    checks++; if (at == 0) begin errors++; $display("FAIL reti_press: got %0d expected nonzero", at); end
    if (at != 0) measure_low(len);
    magic_button = 1'b0;
    fetch(16'h0066, 8'hF5, m);
    fetch(16'h0067, 8'hED, m);
    fetch(16'h0068, 8'h4D, m);
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL reti_first: got %b expected 1", magic_map); end
    fetch(16'h0069, 8'hED, m);
    fetch(16'h006A, 8'h4D, m);
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL reti_second: got %b expected 1", magic_map); end
    fetch(16'h006B, 8'h00, m);
    fetch(16'h006C, 8'h45, m);
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL no_prefix_45: got %b expected 1", magic_map); end
    cyc(20);
    magic_button = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkcpu);
      if (n_nmi !== 1'b1) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL press_in_mapped_nmi: got %b expected 1", ok); end
    checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL press_in_mapped_map: got %b expected 1", magic_map); end
    magic_button = 1'b0;
    cyc(20);
    fetch(16'h006D, 8'hED, m);
    fetch(16'h006E, 8'h45, m);
    fetch(16'h1234, 8'h00, m);
    checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL reti_exit: got %b expected 0", magic_active); end
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkcpu);
      if (n_nmi !== 1'b1) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL no_deferred_press: got %b expected 1", ok); end
  endtask

  task automatic test_reset_mid;
    int at, len;
    logic m;
    cyc(20);
    magic_button = 1'b1;
    wait_fall(40, at);
    checks++; if (at == 0) begin errors++; $display("FAIL midrst_press: got %0d expected nonzero", at); end
    repeat (9) @(negedge clkcpu);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL midrst_n_nmi: got %b expected 1", n_nmi); end
    checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL midrst_active: got %b expected 0", magic_active); end
    checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL midrst_map: got %b expected 0", magic_map); end
    cyc(2);
    rst_n = 1'b1;
    len = 0;
    wait_fall(60, at);
    checks++; if (at == 0) begin errors++; $display("FAIL midrst_repress: got %0d expected nonzero", at); end
    if (at != 0) measure_low(len);
    checks++; if (len != 24) begin errors++; $display("FAIL midrst_pulse_len: got %0d expected 24", len); end
    magic_button = 1'b0;
    for (int i = 0; i < 3; i++) fetch(16'h8000, 8'h00, m);
    checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL midrst_back_idle: got %b expected 0", magic_active); end
  endtask

  initial begin
    bus_if.a = 16'h0000;
    bus_if.d = 8'h00;
    bus_if.m1 = 1'b0;
    bus_if.mreq = 1'b0;
    bus_if.rd = 1'b0;
    test_reset();
    test_bounce();
    test_timeout();
    test_int_delay();
    test_map();
    test_reti();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/magic_nmi.md
# magic_nmi

Magic-button NMI controller in the CPU clock domain, alongside the CPU clock/INT generator. It debounces the front-panel magic button and drives a fixed-length NMI pulse. It then tracks opcode fetches so the service ROM is mapped from the 0x0066 vector fetch until the RETN that ends the handler. Its outputs feed the memory mapper and the CPU's NMI pin.

## Interface
- DEBOUNCE_BITS, 12: debounce counter width; the button must be stable for 2^DEBOUNCE_BITS clkcpu edges.
- NMI_LEN, 24: n_nmi low time in clkcpu cycles (1..255).
- VECTOR_TIMEOUT, 255: M1 fetches allowed between NMI end and the 0x0066 fetch before giving up (1..255).
- rst_n  input  1  reset rst_n, asynchronous, active-low.
- clkcpu  input  1  clock clkcpu, the gated CPU clock; it stalls during contention and turbo wait.
- bus  cpu_bus  -  CPU bus view; uses a[15:0], d[7:0], m1, mreq, rd.
- magic_button  input  1  raw button, active-high, asynchronous.
- n_int  input  1  frame interrupt from the INT generator.
- n_nmi  output  1  to CPU NMI pin, active-low.
- magic_map  output  1  maps service ROM over 0x0000–0x3FFF.
- magic_active  output  1  high in every state except IDLE; drives the status LED.

## Operation
- Synchronizer: 2 flops on magic_button. Debounce (sub-module): the output toggles after the synchronized input differs from it for 2^DEBOUNCE_BITS consecutive edges. The press event is the debounced 0→1 edge.
- Fetch window: fetch = m1 && mreq && rd. While fetch is high, opc <= d and fa <= a on every edge. fetch_end is the first edge with fetch low after one with fetch high; it is a 1-cycle strobe, and opc/fa hold the completed fetch.
- Prefix tracker: ed_pfx <= (opc==8'hED) on each fetch_end. retn = fetch_end && ed_pfx && opc[7:6]==2'b01 && opc[2:0]==3'b101 && opc!=8'h4D. That covers 45,55,5D,65,6D,75,7D; 4D (RETI) is excluded.
- States (nmi_state_t): IDLE, NMI, WAIT_VEC, MAPPED, UNMAP.
  - IDLE → NMI on press. Press events in any other state are discarded.
  - NMI: n_nmi=0, counter counts NMI_LEN cycles, then → WAIT_VEC.
  - WAIT_VEC: on fetch_end with fa==16'h0066 → MAPPED. Otherwise each fetch_end increments the timeout count; at VECTOR_TIMEOUT → IDLE.
  - MAPPED: magic_map=1; on retn → UNMAP.
  - UNMAP: magic_map stays 1 until the next fetch_end, which is the first fetch of the return address, then → IDLE with magic_map=0.
- magic_map is also asserted combinationally during the 0x0066 fetch itself, so the vector comes from service ROM: magic_map = (state==MAPPED||state==UNMAP) || (state==WAIT_VEC && fetch && a==16'h0066).
- n_int: if n_int is low when NMI would start, entry is delayed until n_int is high. NMI never starts inside an INT pulse.

## Timing
- Reset values: state=IDLE, n_nmi=1, magic_map=0, magic_active=0, counters=0, ed_pfx=0, debounced=0.
- n_nmi is a registered output. It falls on the first edge after press (n_int high) and rises exactly NMI_LEN edges later.
- State-derived outputs (magic_active, magic_map outside the 0x0066 fetch term) are registered from state with 1-edge latency.
- A stalled clkcpu freezes all counters; no cycles are lost or added.
- Reset mid-operation: immediate IDLE, n_nmi=1, magic_map=0 asynchronously, even mid-pulse.
- An ED prefix that is split across NMI entry is irrelevant: ed_pfx is cleared by every non-ED fetch_end.
- Simultaneous fetch_end with 0x0066 and timeout expiry: the 0x0066 match wins.

## Structure
- common package: typedef enum logic [2:0] nmi_state_t; localparam NMI_VECTOR=16'h0066; localparam OPC_ED=8'hED, OPC_RETI=8'h4D.
- Sub-module button_debounce (sync + counter, parameter DEBOUNCE_BITS, outputs level and rise strobe). The FSM, fetch tracker and counters live in magic_nmi.

## Test plan
- DEBOUNCE_BITS=4; bounce the button 0/1 every 3 cycles for 40 cycles, then hold 1 → exactly one press; n_nmi low for 24 cycles.
- Press while n_int=0 for 32 cycles → n_nmi falls on the first edge after n_int rises.
- NMI, then fetch at 0x0066 (d=F5), then fetches ED,45 → magic_map=1 from the 0x0066 fetch. It stays 1 through ED 45 and drops after the next fetch at 0x1234.
- In MAPPED, fetch ED,4D (RETI) then ED,4D → magic_map stays 1. Fetch 00,45 → still 1 (no prefix).
- VECTOR_TIMEOUT=3; after NMI, 3 fetches at 0x8000 → back to IDLE, magic_map never 1. A press in MAPPED is ignored.
- Assert rst_n=0 at cycle 10 of the NMI pulse → n_nmi=1, magic_active=0 immediately. After release, the next press runs a full 24-cycle pulse.
